// File: rtl/rv32i_mem_sequencer.sv
// rv32i_mem_sequencer: arbitrates instruction fetch and load/store onto one
// 16-bit halfword memory port, splitting words into two beats, masking
// byte/half stores and extending loads by RV32I funct3.
module rv32i_mem_sequencer #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MEM_ADDR_BITS = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     fetch_req_i,
    input  logic [XLEN-1:0]          fetch_addr_i,
    output logic                     fetch_ready_o,
    input  logic                     data_req_i,
    input  logic                     data_we_i,
    input  logic [XLEN-1:0]          data_addr_i,
    input  logic [2:0]               data_funct3_i,
    input  logic [XLEN-1:0]          data_wdata_i,
    output logic                     data_ready_o,
    output logic [XLEN-1:0]          rdata_o,
    output logic                     fault_o,
    output logic [MEM_ADDR_BITS-1:0] mem_addr_o,
    output logic                     mem_rd_o,
    output logic                     mem_wr_o,
    output logic [1:0]               mem_wmask_o,
    output logic [15:0]              mem_wdata_o,
    input  logic [15:0]              mem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t                   r_state;
    logic                     r_last_data;
    logic                     r_we;
    logic [2:0]               r_funct3;
    logic                     r_addr_b0;
    logic [XLEN-1:0]          r_wdata;
    logic [15:0]              r_lo_half;
    logic                     r_fetch_ready;
    logic                     r_data_ready;
    logic                     r_fault;
    logic [MEM_ADDR_BITS-1:0] r_mem_addr;
    logic                     r_mem_rd;
    logic                     r_mem_wr;
    logic [1:0]               r_mem_wmask;
    logic [15:0]              r_mem_wdata;

    logic                     w_any_req;
    logic                     w_grant_data;
    logic                     w_sel_we;
    logic [2:0]               w_sel_f3;
    logic [XLEN-1:0]          w_sel_addr;
    logic [XLEN-1:0]          w_sel_wdata;
    logic                     w_illegal;
    logic [1:0]               w_lo_mask;
    logic [15:0]              w_lo_wdata;
    logic [7:0]               w_byte;
    logic [XLEN-1:0]          w_rdata;
    logic                     w_unused_addr;

    // Arbitration, request mux and legality/first-beat decode of the granted request
    always_comb begin
        w_any_req    = fetch_req_i | data_req_i;
        w_grant_data = data_req_i & (~fetch_req_i | ~r_last_data);
        w_sel_we     = 1'b0;
        w_sel_f3     = F3_W;
        w_sel_addr   = fetch_addr_i;
        w_sel_wdata  = '0;
        if (w_grant_data) begin
            w_sel_we    = data_we_i;
            w_sel_f3    = data_funct3_i;
            w_sel_addr  = data_addr_i;
            w_sel_wdata = data_wdata_i;
        end
        case (w_sel_f3)
            F3_B:    w_illegal = 1'b0;
            F3_H:    w_illegal = w_sel_addr[0];
            F3_W:    w_illegal = |w_sel_addr[1:0];
            F3_BU:   w_illegal = w_sel_we;
            F3_HU:   w_illegal = w_sel_we | w_sel_addr[0];
            default: w_illegal = 1'b1;
        endcase
        w_lo_mask  = 2'b11;
        w_lo_wdata = w_sel_wdata[15:0];
        if (w_sel_f3 == F3_B) begin
            w_lo_mask  = w_sel_addr[0] ? 2'b10 : 2'b01;
            w_lo_wdata = {w_sel_wdata[7:0], w_sel_wdata[7:0]};
        end
    end

    // Upper address bits beyond the memory port are intentionally ignored
    assign w_unused_addr = ^w_sel_addr[XLEN-1:MEM_ADDR_BITS+1];

    // Access sequencing with registered ready/fault and memory strobes
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state       <= S_IDLE;
            r_last_data   <= 1'b0;
            r_we          <= 1'b0;
            r_funct3      <= 3'b000;
            r_addr_b0     <= 1'b0;
            r_wdata       <= '0;
            r_lo_half     <= '0;
            r_fetch_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            r_fault       <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_wmask   <= 2'b00;
            r_mem_wdata   <= '0;
        end else begin
            r_fetch_ready <= 1'b0;
            r_data_ready  <= 1'b0;
            r_fault       <= 1'b0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_wmask   <= 2'b00;
            r_mem_wdata   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last_data <= w_grant_data;
                        r_we        <= w_sel_we;
                        r_funct3    <= w_sel_f3;
                        r_addr_b0   <= w_sel_addr[0];
                        r_wdata     <= w_sel_wdata;
                        if (w_illegal) begin
                            r_state       <= S_DONE;
                            r_fault       <= 1'b1;
                            r_fetch_ready <= ~w_grant_data;
                            r_data_ready  <= w_grant_data;
                        end else begin
                            r_state    <= S_LO;
                            r_mem_addr <= w_sel_addr[MEM_ADDR_BITS:1];
                            r_mem_rd   <= ~w_sel_we;
                            r_mem_wr   <= w_sel_we;
                            if (w_sel_we) begin
                                r_mem_wmask <= w_lo_mask;
                                r_mem_wdata <= w_lo_wdata;
                            end
                        end
                    end
                end
                S_LO: begin
                    if (r_funct3 == F3_W) begin
                        r_state    <= S_HI;
                        r_mem_addr <= MEM_ADDR_BITS'(r_mem_addr + 1'b1);
                        r_mem_rd   <= ~r_we;
                        r_mem_wr   <= r_we;
                        if (r_we) begin
                            r_mem_wmask <= 2'b11;
                            r_mem_wdata <= r_wdata[31:16];
                        end
                    end else begin
                        r_state       <= S_DONE;
                        r_fetch_ready <= ~r_last_data;
                        r_data_ready  <= r_last_data;
                    end
                end
                S_HI: begin
                    r_lo_half     <= mem_rdata_i;
                    r_state       <= S_DONE;
                    r_fetch_ready <= ~r_last_data;
                    r_data_ready  <= r_last_data;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Load result: memory returns the final halfword during DONE, so extend it here
    always_comb begin
        w_rdata = '0;
        w_byte  = r_addr_b0 ? mem_rdata_i[15:8] : mem_rdata_i[7:0];
        if ((r_state == S_DONE) && !r_fault && !r_we) begin
            case (r_funct3)
                F3_W:    w_rdata = XLEN'({mem_rdata_i, r_lo_half});
                F3_B:    w_rdata = {{(XLEN-8){w_byte[7]}}, w_byte};
                F3_BU:   w_rdata = {{(XLEN-8){1'b0}}, w_byte};
                F3_H:    w_rdata = {{(XLEN-16){mem_rdata_i[15]}}, mem_rdata_i};
                F3_HU:   w_rdata = {{(XLEN-16){1'b0}}, mem_rdata_i};
                default: w_rdata = '0;
            endcase
        end
    end

    assign fetch_ready_o = r_fetch_ready;
    assign data_ready_o  = r_data_ready;
    assign fault_o       = r_fault;
    assign rdata_o       = w_rdata;
    assign mem_addr_o    = r_mem_addr;
    assign mem_rd_o      = r_mem_rd;
    assign mem_wr_o      = r_mem_wr;
    assign mem_wmask_o   = r_mem_wmask;
    assign mem_wdata_o   = r_mem_wdata;

endmodule

// File: tb/tb_rv32i_mem_sequencer.sv
// Bench for rv32i_mem_sequencer: halfword memory model, scoreboard of
// expected completions, and a strobe trace for per-beat checks.
module tb_rv32i_mem_sequencer;

    logic        clk_i;
    logic        reset_i;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_ready_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [2:0]  data_funct3_i;
    logic [31:0] data_wdata_i;
    logic        data_ready_o;
    logic [31:0] rdata_o;
    logic        fault_o;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [1:0]  mem_wmask_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
        bit          fault;
        int          lat;
        string       tag;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [1:0]  mask;
        logic [15:0] wd;
    } beat_t;

    exp_t  sb[$];
    beat_t trace[$];
    logic [15:0] mem [0:65535];

    rv32i_mem_sequencer #(.XLEN(32), .MEM_ADDR_BITS(16)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .fetch_req_i   (fetch_req_i),
        .fetch_addr_i  (fetch_addr_i),
        .fetch_ready_o (fetch_ready_o),
        .data_req_i    (data_req_i),
        .data_we_i     (data_we_i),
        .data_addr_i   (data_addr_i),
        .data_funct3_i (data_funct3_i),
        .data_wdata_i  (data_wdata_i),
        .data_ready_o  (data_ready_o),
        .rdata_o       (rdata_o),
        .fault_o       (fault_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rd_o      (mem_rd_o),
        .mem_wr_o      (mem_wr_o),
        .mem_wmask_o   (mem_wmask_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Halfword memory with one-cycle read latency and byte-lane writes
    always @(posedge clk_i) begin
        if (mem_rd_o) mem_rdata_i <= mem[mem_addr_o];
        if (mem_wr_o) begin
            if (mem_wmask_o[0]) mem[mem_addr_o][7:0]  <= mem_wdata_o[7:0];
            if (mem_wmask_o[1]) mem[mem_addr_o][15:8] <= mem_wdata_o[15:8];
        end
    end

    // Strobe trace and read/write exclusivity check
    always @(negedge clk_i) begin
        beat_t b;
        if (mem_rd_o || mem_wr_o) begin
            b.rd = mem_rd_o; b.wr = mem_wr_o; b.addr = mem_addr_o;
            b.mask = mem_wmask_o; b.wd = mem_wdata_o;
            trace.push_back(b);
        end
        total++;
        assert (!(mem_rd_o && mem_wr_o)) else begin
            bad++;
            $error("FAIL rd_wr_excl: observed rd=%0b wr=%0b expected not both", mem_rd_o, mem_wr_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_data, input logic [31:0] rd, input bit flt,
                            input int lat, input string tag);
        exp_t e;
        e.is_data = is_data; e.rdata = rd; e.fault = flt; e.lat = lat; e.tag = tag;
        sb.push_back(e);
    endtask

    // Wait (bounded) for the next ready pulse and compare it with the scoreboard head
    task automatic collect();
        exp_t e;
        int   cyc;
        bit   got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            @(posedge clk_i); #1;
            cyc++;
            got = fetch_ready_o | data_ready_o;
        end
        if (sb.size() > 0) e = sb.pop_front();
        else begin
            e.is_data = 1'b0; e.rdata = '0; e.fault = 1'b0; e.lat = 0; e.tag = "unexpected";
        end
        chk({e.tag, ":ready_seen"}, 32'(got), 32'd1);
        chk({e.tag, ":latency"}, 32'(cyc), 32'(e.lat));
        chk({e.tag, ":which_ready"}, 32'({fetch_ready_o, data_ready_o}),
            e.is_data ? 32'd1 : 32'd2);
        chk({e.tag, ":rdata"}, rdata_o, e.rdata);
        chk({e.tag, ":fault"}, 32'(fault_o), 32'(e.fault));
    endtask

    task automatic access(input bit is_data, input bit we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_fault,
                          input int exp_lat, input int exp_beats, input string tag);
        @(posedge clk_i); #1;
        trace.delete();
        push_exp(is_data, exp_rd, exp_fault, exp_lat, tag);
        if (is_data) begin
            data_req_i = 1'b1; data_we_i = we; data_funct3_i = f3;
            data_addr_i = addr; data_wdata_i = wd;
        end else begin
            fetch_req_i = 1'b1; fetch_addr_i = addr;
        end
        collect();
        fetch_req_i = 1'b0;
        data_req_i  = 1'b0;
        chk({tag, ":beats"}, 32'(trace.size()), 32'(exp_beats));
    endtask

    task automatic chk_beat(input string tag, input int idx, input bit wr,
                            input logic [15:0] addr, input logic [1:0] mask,
                            input logic [15:0] wd);
        if (trace.size() > idx) begin
            chk({tag, ":rdwr"}, 32'({trace[idx].rd, trace[idx].wr}), wr ? 32'd1 : 32'd2);
            chk({tag, ":addr"}, 32'(trace[idx].addr), 32'(addr));
            if (wr) begin
                chk({tag, ":mask"}, 32'(trace[idx].mask), 32'(mask));
                chk({tag, ":wdata"}, 32'(trace[idx].wd), 32'(wd));
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ":ctl"}, 32'({fetch_ready_o, data_ready_o, fault_o, mem_rd_o, mem_wr_o, mem_wmask_o}), 32'd0);
        chk({tag, ":rdata"}, rdata_o, 32'd0);
        chk({tag, ":maddr"}, 32'(mem_addr_o), 32'd0);
        chk({tag, ":mwdata"}, 32'(mem_wdata_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[8] = 16'h1234;
        mem[9] = 16'hABCD;
        mem_rdata_i   = 16'h0000;
        reset_i       = 1'b0;
        fetch_req_i   = 1'b0;
        fetch_addr_i  = '0;
        data_req_i    = 1'b0;
        data_we_i     = 1'b0;
        data_addr_i   = '0;
        data_funct3_i = 3'b000;
        data_wdata_i  = '0;
        #2;
        chk_all_zero("reset");
        #11 reset_i = 1'b1;

        // Simultaneous requests right after reset: data wins, fetch follows
        @(posedge clk_i); #1;
        trace.delete();
        push_exp(1'b1, 32'h0000_1234, 1'b0, 2, "tie1_data_lhu");
        push_exp(1'b0, 32'hABCD_1234, 1'b0, 4, "tie1_fetch");
        data_req_i = 1'b1; data_we_i = 1'b0; data_funct3_i = 3'b101; data_addr_i = 32'h10;
        fetch_req_i = 1'b1; fetch_addr_i = 32'h10;
        collect();
        data_req_i = 1'b0;
        collect();
        fetch_req_i = 1'b0;

        // Data-only access makes data the last grant, so the next tie goes to fetch
        access(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_ABCD, 1'b0, 2, 1, "lh_0x12");
        @(posedge clk_i); #1;
        push_exp(1'b0, 32'hABCD_1234, 1'b0, 3, "tie2_fetch");
        push_exp(1'b1, 32'h0000_0034, 1'b0, 3, "tie2_data_lbu");
        data_req_i = 1'b1; data_we_i = 1'b0; data_funct3_i = 3'b100; data_addr_i = 32'h10;
        fetch_req_i = 1'b1; fetch_addr_i = 32'h10;
        collect();
        fetch_req_i = 1'b0;
        collect();
        data_req_i = 1'b0;

        // Fetch-only word read
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hABCD_1234, 1'b0, 3, 2, "fetch_0x10");
        chk_beat("fetch_b0", 0, 1'b0, 16'h0008, 2'b00, 16'h0000);
        chk_beat("fetch_b1", 1, 1'b0, 16'h0009, 2'b00, 16'h0000);

        // Byte store on the high lane, then unsigned/signed byte loads
        access(1'b1, 1'b1, 3'b000, 32'h5, 32'h0000_00A5, 32'h0, 1'b0, 2, 1, "sb_0x5");
        chk_beat("sb_b0", 0, 1'b1, 16'h0002, 2'b10, 16'hA5A5);
        access(1'b1, 1'b0, 3'b100, 32'h5, 32'h0, 32'h0000_00A5, 1'b0, 2, 1, "lbu_0x5");
        access(1'b1, 1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFF_FFA5, 1'b0, 2, 1, "lb_0x5");
        access(1'b1, 1'b0, 3'b000, 32'h4, 32'h0, 32'h0000_0000, 1'b0, 2, 1, "lb_0x4");

        // Misaligned and undefined accesses fault with no memory traffic
        access(1'b1, 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, 1, 0, "lw_misal");
        access(1'b1, 1'b1, 3'b001, 32'h1, 32'hFFFF, 32'h0, 1'b1, 1, 0, "sh_misal");
        access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, "f3_011");
        access(1'b1, 1'b1, 3'b100, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, "sbu_illegal");
        access(1'b1, 1'b0, 3'b111, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0, "f3_111");

        // Word store at the top of the halfword space, then read-backs
        access(1'b1, 1'b1, 3'b010, 32'h0001_FFFC, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 2, "sw_top");
        chk_beat("sw_b0", 0, 1'b1, 16'hFFFE, 2'b11, 16'hBEEF);
        chk_beat("sw_b1", 1, 1'b1, 16'hFFFF, 2'b11, 16'hDEAD);
        access(1'b1, 1'b0, 3'b001, 32'h0001_FFFE, 32'h0, 32'hFFFF_DEAD, 1'b0, 2, 1, "lh_top");
        access(1'b1, 1'b0, 3'b101, 32'h0001_FFFC, 32'h0, 32'h0000_BEEF, 1'b0, 2, 1, "lhu_top");
        access(1'b1, 1'b0, 3'b010, 32'h0001_FFFC, 32'h0, 32'hDEAD_BEEF, 1'b0, 3, 2, "lw_top");

        // Reset during the high beat of a word load abandons it
        @(posedge clk_i); #1;
        data_req_i = 1'b1; data_we_i = 1'b0; data_funct3_i = 3'b010; data_addr_i = 32'h10;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        chk("rst_hi:rd", 32'(mem_rd_o), 32'd1);
        chk("rst_hi:addr", 32'(mem_addr_o), 32'h9);
        reset_i = 1'b0;
        data_req_i = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        #2 reset_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("rst_no_ready", 32'({fetch_ready_o, data_ready_o}), 32'd0);
        end
        access(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hABCD_1234, 1'b0, 3, 2, "fetch_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
